ks_add_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one pipelined 16-bit Kogge-Stone adder core among NREQ requesters in the FFT datapath (butterfly real/imag add paths, address/twiddle index updates). It accepts at most one operand pair per cycle via valid/ready, tags each operation with the requester index, and returns sum, carry-out and tag after the fixed adder latency. It also supports bounded locked bursts and a global pipeline hold.

---
 rtl/fft_pkg.sv | 11 +
 rtl/ks_add_16b_pipe.sv | 61 ++++++
 rtl/ks_add_arb.sv | 112 +++++++++++
 tb/tb_ks_add_arb.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT datapath constants: adder width/latency and tag-width helper.
package fft_pkg;

    localparam int KS_W   = 16;
    localparam int KS_LAT = 5;

    function automatic int tag_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ks_add_16b_pipe.sv
// 16-bit Kogge-Stone adder, 5 register stages: PG, prefix L1..L3, (L4 + sum).
module ks_add_16b_pipe
    import fft_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_en,
    input  logic [KS_W-1:0] i_a,
    input  logic [KS_W-1:0] i_b,
    input  logic            i_c0,
    output logic [KS_W-1:0] o_sum,
    output logic            o_c16
);
    localparam int NST = 4;

    logic [NST-1:0][KS_W-1:0] g_q, g_d, p_q, p_d, h_q, h_d;
    logic [NST-1:0]           c_q, c_d;
    logic [KS_W-1:0]          g_fin, sum_d, sum_q;
    logic                     c16_q;

    // Carry-in is folded into bit 0 so the final group generate G[i] is the carry out of bit i.
    assign h_d[0] = i_a ^ i_b;
    assign p_d[0] = i_a ^ i_b;
    assign g_d[0] = (i_a & i_b) | {{(KS_W-1){1'b0}}, (i_a[0] ^ i_b[0]) & i_c0};
    assign c_d[0] = i_c0;

    generate
        for (genvar gi = 1; gi < NST; gi++) begin : g_lvl
            localparam int D = 1 << (gi - 1);
            assign g_d[gi] = g_q[gi-1] | (p_q[gi-1] & (g_q[gi-1] << D));
            assign p_d[gi] = p_q[gi-1] & (p_q[gi-1] << D);
            assign h_d[gi] = h_q[gi-1];
            assign c_d[gi] = c_q[gi-1];
        end
    endgenerate

    assign g_fin = g_q[NST-1] | (p_q[NST-1] & (g_q[NST-1] << 8));
    assign sum_d = h_q[NST-1] ^ {g_fin[KS_W-2:0], c_q[NST-1]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            g_q   <= '0;
            p_q   <= '0;
            h_q   <= '0;
            c_q   <= '0;
            sum_q <= '0;
            c16_q <= 1'b0;
        end else if (i_en) begin
            g_q   <= g_d;
            p_q   <= p_d;
            h_q   <= h_d;
            c_q   <= c_d;
            sum_q <= sum_d;
            c16_q <= g_fin[KS_W-1];
        end
    end

    assign o_sum = sum_q;
    assign o_c16 = c16_q;

endmodule

// File: rtl/ks_add_arb.sv
// Round-robin arbiter with bounded lock bursts sharing one pipelined KS adder;
// a tag/valid pipe tracks requester ids alongside the adder core.
module ks_add_arb
    import fft_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int LAT       = KS_LAT,
    parameter int BURST_MAX = 4,
    parameter int IDW       = tag_width(NREQ)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_hold,
    input  logic [NREQ-1:0]      i_req_valid,
    input  logic [NREQ-1:0]      i_req_lock,
    input  logic [KS_W*NREQ-1:0] i_req_a,
    input  logic [KS_W*NREQ-1:0] i_req_b,
    input  logic [NREQ-1:0]      i_req_c0,
    output logic [NREQ-1:0]      o_req_ready,
    output logic                 o_rsp_valid,
    output logic [IDW-1:0]       o_rsp_id,
    output logic [KS_W-1:0]      o_rsp_sum,
    output logic                 o_rsp_cout,
    output logic                 o_busy
);
    localparam int BW = $clog2(BURST_MAX + 1);

    logic [IDW-1:0]           last_q, last_d;
    logic [BW-1:0]            burst_q, burst_d;
    logic                     lock_q, lock_d;
    logic [IDW-1:0]           rr_win, cand, win;
    logic                     rr_found, lock_grant, xfer;
    logic [KS_W-1:0]          a_arr [NREQ];
    logic [KS_W-1:0]          b_arr [NREQ];
    logic [LAT-1:0]           vld_q;
    logic [LAT-1:0][IDW-1:0]  id_q;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ops
            assign a_arr[gi] = i_req_a[KS_W*gi +: KS_W];
            assign b_arr[gi] = i_req_b[KS_W*gi +: KS_W];
        end
    endgenerate

    always_comb begin
        rr_win   = '0;
        rr_found = 1'b0;
        cand     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last_q) + k) % NREQ);
            if (!rr_found && i_req_valid[cand]) begin
                rr_found = 1'b1;
                rr_win   = cand;
            end
        end
        // Lock priority lapses for one arbitration once the burst limit is hit.
        lock_grant  = lock_q && (burst_q < BW'(BURST_MAX)) && i_req_valid[last_q];
        win         = lock_grant ? last_q : rr_win;
        xfer        = i_rst_n && !i_hold && (lock_grant || rr_found);
        o_req_ready = '0;
        if (xfer) o_req_ready[win] = 1'b1;
    end

    always_comb begin
        last_d  = last_q;
        burst_d = burst_q;
        lock_d  = lock_q;
        if (xfer) begin
            last_d  = win;
            lock_d  = i_req_lock[win];
            if (!i_req_lock[win]) burst_d = '0;
            else                  burst_d = lock_grant ? burst_q + BW'(1) : BW'(1);
        end else if (!i_hold) begin
            lock_d  = 1'b0;
            burst_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_q  <= IDW'(NREQ - 1);
            burst_q <= '0;
            lock_q  <= 1'b0;
            vld_q   <= '0;
            id_q    <= '0;
        end else begin
            last_q  <= last_d;
            burst_q <= burst_d;
            lock_q  <= lock_d;
            if (!i_hold) begin
                vld_q <= {vld_q[LAT-2:0], xfer};
                id_q  <= {id_q[LAT-2:0], win};
            end
        end
    end

    ks_add_16b_pipe u_core (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (~i_hold),
        .i_a     (a_arr[win]),
        .i_b     (b_arr[win]),
        .i_c0    (i_req_c0[win]),
        .o_sum   (o_rsp_sum),
        .o_c16   (o_rsp_cout)
    );

    assign o_rsp_valid = vld_q[LAT-1];
    assign o_rsp_id    = id_q[LAT-1];
    assign o_busy      = |vld_q;

endmodule

// File: tb/tb_ks_add_arb.sv
// Directed + randomized bench for ks_add_arb with an in-order latency-tracking scoreboard.
module tb_ks_add_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        hold;
    logic [3:0]  valid, lock, c0;
    logic [63:0] a_bus, b_bus;
    logic [3:0]  ready;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_sum;
    logic        rsp_cout, busy;

    int checks_cnt = 0;
    int errors_cnt = 0;

    always #5 clk = ~clk;

    ks_add_arb #(.NREQ(4), .LAT(5), .BURST_MAX(4)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_hold      (hold),
        .i_req_valid (valid),
        .i_req_lock  (lock),
        .i_req_a     (a_bus),
        .i_req_b     (b_bus),
        .i_req_c0    (c0),
        .o_req_ready (ready),
        .o_rsp_valid (rsp_valid),
        .o_rsp_id    (rsp_id),
        .o_rsp_sum   (rsp_sum),
        .o_rsp_cout  (rsp_cout),
        .o_busy      (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [16:0] res;
        logic [1:0]  id;
        int          due;
    } exp_t;

    exp_t       sb_q[$];
    int         grant_log[$];
    int         grant_cyc[$];
    logic [3:0] acc_vec = '0;
    int         cyc = 0;
    int         beats[4];
    logic [3:0] lock_mode = '0;
    bit         fixed_ops = 1'b0;
    bit         rand_mode = 1'b0;
    exp_t       mon_e;
    int         mon_k;
    logic [16:0] mon_r;

    // Monitor: samples at negedge, i.e. the values the next rising edge will see.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            sb_q.delete();
            acc_vec = '0;
        end else begin
            check_val("rdy_onehot", 32'($onehot0(ready)), 1);
            check_val("rdy_valid", 32'(ready & ~valid), 0);
            if (hold) check_val("rdy_hold", 32'(ready), 0);
            if (rsp_valid && !hold) begin
                check_val("rsp_expected", 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    check_val("rsp_sum", 32'(rsp_sum), 32'(mon_e.res[15:0]));
                    check_val("rsp_cout", 32'(rsp_cout), 32'(mon_e.res[16]));
                    check_val("rsp_id", 32'(rsp_id), 32'(mon_e.id));
                    check_val("rsp_lat", 32'(cyc), 32'(mon_e.due));
                    if (!rand_mode)
                        $display("rsp cyc=%0d id=%0d sum=%04h cout=%0b", cyc, rsp_id, rsp_sum, rsp_cout);
                end
            end
            if (hold) foreach (sb_q[i]) sb_q[i].due++;
            acc_vec = ready & valid;
            if (|acc_vec) begin
                mon_k = 0;
                for (int i = 0; i < 4; i++) if (acc_vec[i]) mon_k = i;
                mon_r = {1'b0, a_bus[16*mon_k +: 16]} + {1'b0, b_bus[16*mon_k +: 16]} + 17'(c0[mon_k]);
                mon_e.res = mon_r;
                mon_e.id  = 2'(mon_k);
                mon_e.due = cyc + 5;
                sb_q.push_back(mon_e);
                grant_log.push_back(mon_k);
                grant_cyc.push_back(cyc);
            end
        end
    end

    task automatic apply();
        for (int i = 0; i < 4; i++) begin
            valid[i] = beats[i] > 0;
            lock[i]  = lock_mode[i] && (beats[i] > 0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_mode) begin
            valid = 4'($urandom);
            lock  = 4'($urandom);
            hold  = ($urandom_range(0, 7) == 0);
        end else begin
            for (int i = 0; i < 4; i++) if (acc_vec[i] && beats[i] > 0) beats[i]--;
            apply();
        end
        if (!fixed_ops) begin
            a_bus = {$urandom, $urandom};
            b_bus = {$urandom, $urandom};
            c0    = 4'($urandom);
        end
    endtask

    task automatic run_idle(input string tag, input int max);
        int n = 0;
        while (n < max && (beats[0] + beats[1] + beats[2] + beats[3]) != 0) begin
            step();
            n++;
        end
        check_val({tag, "_idle"}, 32'(beats[0] + beats[1] + beats[2] + beats[3]), 0);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        hold = 1'b0;
        while (n < 30 && sb_q.size() != 0) begin
            step();
            n++;
        end
        check_val({tag, "_drain"}, 32'(sb_q.size()), 0);
        step();
        step();
        check_val({tag, "_busy0"}, 32'(busy), 0);
    endtask

    task automatic check_grants(input string tag, input int exp [16], input int n);
        check_val({tag, "_ngrant"}, 32'(grant_log.size()), 32'(n));
        for (int i = 0; i < n && i < grant_log.size(); i++)
            check_val($sformatf("%s_grant%0d", tag, i), 32'(grant_log[i]), 32'(exp[i]));
    endtask

    int exp_g [16];
    logic [15:0] snap_sum;
    logic [1:0]  snap_id;
    logic        snap_valid, snap_cout;
    bit          seen;

    initial begin
        hold = 0; valid = 0; lock = 0; c0 = 0; a_bus = 0; b_bus = 0;
        for (int i = 0; i < 4; i++) beats[i] = 0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 valid = 4'hF;
        #1;
        check_val("rst_ready", 32'(ready), 0);
        check_val("rst_rsp_valid", 32'(rsp_valid), 0);
        check_val("rst_rsp_id", 32'(rsp_id), 0);
        check_val("rst_rsp_sum", 32'(rsp_sum), 0);
        check_val("rst_rsp_cout", 32'(rsp_cout), 0);
        check_val("rst_busy", 32'(busy), 0);
        valid = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // All four requesters, no lock: plain rotation starting at 0.
        for (int i = 0; i < 4; i++) beats[i] = 2;
        grant_log.delete();
        apply();
        run_idle("t1", 40);
        exp_g = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0};
        check_grants("t1", exp_g, 8);
        drain("t1");

        // Requester 2 alone: FFFF + 0001 wraps with carry-out, back-to-back beats.
        fixed_ops = 1'b1;
        a_bus = '0; b_bus = '0; c0 = '0;
        a_bus[47:32] = 16'hFFFF;
        b_bus[47:32] = 16'h0001;
        beats[2] = 3;
        grant_log.delete();
        grant_cyc.delete();
        apply();
        seen = 1'b0;
        for (int n = 0; n < 12; n++) begin
            step();
            if (rsp_valid && !seen) begin
                seen = 1'b1;
                check_val("t2_sum", 32'(rsp_sum), 32'h0000);
                check_val("t2_cout", 32'(rsp_cout), 1);
                check_val("t2_id", 32'(rsp_id), 2);
            end
        end
        check_val("t2_seen", 32'(seen), 1);
        exp_g = '{2, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        check_grants("t2", exp_g, 3);
        if (grant_cyc.size() == 3) check_val("t2_b2b", 32'(grant_cyc[2] - grant_cyc[0]), 2);
        drain("t2");
        fixed_ops = 1'b0;

        // Reset with four operations in flight.
        for (int i = 0; i < 4; i++) beats[i] = 1;
        apply();
        repeat (4) step();
        check_val("t5_busy_pre", 32'(busy), 1);
        valid = 4'hF;
        #3 rst_n = 1'b0;
        #1;
        check_val("t5_ready", 32'(ready), 0);
        check_val("t5_rsp_valid", 32'(rsp_valid), 0);
        check_val("t5_rsp_sum", 32'(rsp_sum), 0);
        check_val("t5_rsp_id", 32'(rsp_id), 0);
        check_val("t5_busy", 32'(busy), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        grant_log.delete();
        for (int i = 0; i < 4; i++) beats[i] = 1;
        apply();
        run_idle("t5", 20);
        exp_g = '{0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        check_grants("t5", exp_g, 4);
        drain("t5");

        // Locked burst from requester 1 capped at four, requester 3 competing.
        lock_mode = 4'b0010;
        beats[1] = 6;
        beats[3] = 1;
        grant_log.delete();
        apply();
        run_idle("t3", 30);
        exp_g = '{1, 1, 1, 1, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        check_grants("t3", exp_g, 7);
        drain("t3");
        lock_mode = '0;

        // Three-cycle hold in the middle of a full-rate stream.
        for (int i = 0; i < 4; i++) beats[i] = 3;
        grant_log.delete();
        apply();
        repeat (6) step();
        hold = 1'b1;
        snap_valid = rsp_valid;
        snap_id    = rsp_id;
        snap_sum   = rsp_sum;
        snap_cout  = rsp_cout;
        check_val("t4_rsp_live", 32'(rsp_valid), 1);
        for (int n = 0; n < 3; n++) begin
            step();
            check_val("t4_frz_valid", 32'(rsp_valid), 32'(snap_valid));
            check_val("t4_frz_id", 32'(rsp_id), 32'(snap_id));
            check_val("t4_frz_sum", 32'(rsp_sum), 32'(snap_sum));
            check_val("t4_frz_cout", 32'(rsp_cout), 32'(snap_cout));
        end
        hold = 1'b0;
        run_idle("t4", 30);
        exp_g = '{2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 0, 0, 0, 0};
        check_grants("t4", exp_g, 12);
        drain("t4");

        // Random valid/lock/hold/operands; scoreboard and ready properties check every cycle.
        rand_mode = 1'b1;
        repeat (10000) step();
        rand_mode = 1'b0;
        for (int i = 0; i < 4; i++) beats[i] = 0;
        apply();
        drain("rnd");

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
